// File: rtl/lap_display_ctrl.sv
// Lap/split capture and recall front end for the stopwatch 7-segment display.
// Ports: clk, rst_n, tick_10ms, btn_lap, btn_recall, running, clear_laps,
//    time_bcd[15:0] in; disp_bcd[15:0], disp_is_lap, lap_idx[1:0],
//    lap_count[2:0], overflow out. Optional macro LAP_HOLD_EN adds HOLD.
module lap_display_ctrl #(
   parameter int DEB_TICKS    = 2,
   parameter int RECALL_TICKS = 500,
   parameter int HOLD_TICKS   = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_10ms,
   input  logic        btn_lap,
   input  logic        btn_recall,
   input  logic        running,
   input  logic        clear_laps,
   input  logic [15:0] time_bcd,
   output logic [15:0] disp_bcd,
   output logic        disp_is_lap,
   output logic [1:0]  lap_idx,
   output logic [2:0]  lap_count,
   output logic        overflow
);

   localparam int DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
   localparam int TMAX = (RECALL_TICKS > HOLD_TICKS) ? RECALL_TICKS
                                                     : HOLD_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_TICKS - 1);
   localparam logic [TW-1:0] RECALL_LAST = TW'(RECALL_TICKS - 1);

   localparam logic [1:0] ST_LIVE   = 2'd0;
   localparam logic [1:0] ST_RECALL = 2'd1;
`ifdef LAP_HOLD_EN
   localparam logic [1:0] ST_HOLD   = 2'd2;
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
`endif

   // ---------------- button conditioning ----------------
   // index 0 = lap, index 1 = recall
   logic [1:0]    btn_raw;
   logic [1:0]    s1_q, s1_d;
   logic [1:0]    s2_q, s2_d;
   logic [1:0]    lvl_q, lvl_d;
   logic [1:0]    arm_q, arm_d;
   logic [1:0]    ev_q, ev_d;
   logic [DW-1:0] dcnt_q [2];
   logic [DW-1:0] dcnt_d [2];

   assign btn_raw = {btn_recall, btn_lap};

   // A button must be seen released after reset before it may fire:
   // arm_q sets on the first tick where both the synced and accepted
   // levels are low. The sync flops reset high so a button held through
   // reset never looks released until it really is.
   always_comb begin
      s1_d  = btn_raw;
      s2_d  = s1_q;
      lvl_d = lvl_q;
      arm_d = arm_q;
      for (int i = 0; i < 2; i++) begin
         dcnt_d[i] = dcnt_q[i];
         if (tick_10ms) begin
            if (s2_q[i] != lvl_q[i]) begin
               if (dcnt_q[i] == DEB_LAST) begin
                  lvl_d[i]  = s2_q[i];
                  dcnt_d[i] = '0;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + DW'(1);
               end
            end else begin
               dcnt_d[i] = '0;
            end
            if (!arm_q[i] && !s2_q[i] && !lvl_q[i]) begin
               arm_d[i] = 1'b1;
            end
         end
      end
      ev_d = lvl_d & ~lvl_q & arm_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 2'b11;
         s2_q      <= 2'b11;
         lvl_q     <= 2'b00;
         arm_q     <= 2'b00;
         ev_q      <= 2'b00;
         dcnt_q[0] <= '0;
         dcnt_q[1] <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         lvl_q     <= lvl_d;
         arm_q     <= arm_d;
         ev_q      <= ev_d;
         dcnt_q[0] <= dcnt_d[0];
         dcnt_q[1] <= dcnt_d[1];
      end
   end

   logic lap_ev;
   logic rec_ev;

   assign lap_ev = ev_q[0];
   assign rec_ev = ev_q[1];

   // ---------------- lap buffer and mode control ----------------
   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [15:0]   mem_q [4];
   logic [15:0]   mem_d [4];
   logic [15:0]   disp_q, disp_d;
   logic          is_lap_q, is_lap_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      tmr_d   = tmr_q;
      for (int k = 0; k < 4; k++) begin
         mem_d[k] = mem_q[k];
      end

      if (clear_laps) begin
         state_d = ST_LIVE;
         idx_d   = 2'd0;
         cnt_d   = 3'd0;
         ovf_d   = 1'b0;
         tmr_d   = '0;
      end else if (state_q == ST_RECALL) begin
         if (lap_ev) begin
            state_d = ST_LIVE;
            tmr_d   = '0;
         end else if (rec_ev) begin
            tmr_d = '0;
            if ({1'b0, idx_q} == cnt_q - 3'd1) begin
               idx_d = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end else if (tick_10ms) begin
            if (tmr_q == RECALL_LAST) begin
               state_d = ST_LIVE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
      end else begin
         // LIVE, and HOLD which reacts to presses exactly like LIVE
         if (lap_ev) begin
            if (running) begin
               if (!cnt_q[2]) begin
                  mem_d[cnt_q[1:0]] = time_bcd;
                  cnt_d = cnt_q + 3'd1;
`ifdef LAP_HOLD_EN
                  state_d = ST_HOLD;
                  idx_d   = cnt_q[1:0];
                  tmr_d   = '0;
`endif
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end else if (rec_ev && cnt_q != 3'd0) begin
            state_d = ST_RECALL;
            idx_d   = 2'd0;
            tmr_d   = '0;
         end
`ifdef LAP_HOLD_EN
         else if (state_q == ST_HOLD && tick_10ms) begin
            if (tmr_q == HOLD_LAST) begin
               state_d = ST_LIVE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
`endif
      end
   end

   // Display follows the current mode, so it lags lap_idx by one clk
   // and in LIVE shows time_bcd from the previous clk.
   always_comb begin
      disp_d   = time_bcd;
      is_lap_d = 1'b0;
      if (state_q != ST_LIVE) begin
         disp_d   = mem_q[idx_q];
         is_lap_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LIVE;
         idx_q    <= 2'd0;
         cnt_q    <= 3'd0;
         ovf_q    <= 1'b0;
         tmr_q    <= '0;
         disp_q   <= 16'h0000;
         is_lap_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         tmr_q    <= tmr_d;
         disp_q   <= disp_d;
         is_lap_q <= is_lap_d;
      end
   end

   // Buffer contents are never shown before being written, so no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         mem_q[k] <= mem_d[k];
      end
   end

   assign disp_bcd    = disp_q;
   assign disp_is_lap = is_lap_q;
   assign lap_idx     = idx_q;
   assign lap_count   = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Bench for lap_display_ctrl: random button/control stimulus, queue of
// expected display states, monitor compares on request strobes.
module tb_lap_display_ctrl;

   localparam int DEB = 2;
   localparam int RT  = 500;
   localparam int HT  = 100;
   localparam int TP  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_10ms = 1'b0;
   logic        btn_lap = 1'b0;
   logic        btn_recall = 1'b0;
   logic        running = 1'b0;
   logic        clear_laps = 1'b0;
   logic [15:0] time_bcd = 16'h0000;
   logic [15:0] disp_bcd;
   logic        disp_is_lap;
   logic [1:0]  lap_idx;
   logic [2:0]  lap_count;
   logic        overflow;

   lap_display_ctrl #(
      .DEB_TICKS(DEB),
      .RECALL_TICKS(RT),
      .HOLD_TICKS(HT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick_10ms(tick_10ms),
      .btn_lap(btn_lap),
      .btn_recall(btn_recall),
      .running(running),
      .clear_laps(clear_laps),
      .time_bcd(time_bcd),
      .disp_bcd(disp_bcd),
      .disp_is_lap(disp_is_lap),
      .lap_idx(lap_idx),
      .lap_count(lap_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int tick_cnt = 0;

   initial begin
      forever begin
         repeat (TP - 1) @(posedge clk);
         #1 tick_10ms = 1'b1;
         tick_cnt++;
         @(posedge clk);
         #1 tick_10ms = 1'b0;
      end
   end

   initial begin
      #950_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       nm;
      logic [15:0] disp;
      logic        lap;
      logic [1:0]  idx;
      logic [2:0]  cnt;
      logic        ovf;
      bit          idx_care;
   } exp_t;

   exp_t sb[$];
   logic chk_req = 1'b0;
   int   errors = 0;
   int   checks = 0;

   // monitor
   always @(negedge clk) begin
      if (chk_req) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: strobe with no expectation");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (disp_bcd !== e.disp || disp_is_lap !== e.lap ||
                lap_count !== e.cnt || overflow !== e.ovf ||
                (e.idx_care && lap_idx !== e.idx)) begin
               errors++;
               $display("FAIL %s: got disp=%h lap=%b idx=%0d cnt=%0d ovf=%b, exp disp=%h lap=%b idx=%0d(%s) cnt=%0d ovf=%b",
                        e.nm, disp_bcd, disp_is_lap, lap_idx, lap_count,
                        overflow, e.disp, e.lap, e.idx,
                        e.idx_care ? "care" : "dc", e.cnt, e.ovf);
            end
         end
      end
   end

   // reference model: mode 0 = live, 1 = recall, 2 = hold
   logic [15:0] m_laps[$];
   bit          m_ovf = 1'b0;
   int          m_mode = 0;
   int          m_idx = 0;

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      v[15:12] = 4'($urandom_range(5));
      v[11:8]  = 4'($urandom_range(9));
      v[7:4]   = 4'($urandom_range(9));
      v[3:0]   = 4'($urandom_range(9));
      return v;
   endfunction

   task automatic strobe();
      @(posedge clk);
      #1 chk_req = 1'b1;
      @(posedge clk);
      #1 chk_req = 1'b0;
   endtask

   task automatic push_exp(input string nm, input logic [15:0] d,
                           input logic l, input logic [1:0] ix,
                           input logic [2:0] c, input logic o,
                           input bit care);
      exp_t e;
      e.nm = nm;
      e.disp = d;
      e.lap = l;
      e.idx = ix;
      e.cnt = c;
      e.ovf = o;
      e.idx_care = care;
      sb.push_back(e);
      strobe();
   endtask

   task automatic expect_now(input string nm);
      if (m_mode == 0) begin
         push_exp(nm, time_bcd, 1'b0, 2'd0, 3'(m_laps.size()),
                  m_ovf, 1'b0);
      end else begin
         push_exp(nm, m_laps[m_idx], 1'b1, 2'(m_idx),
                  3'(m_laps.size()), m_ovf, 1'b1);
      end
   endtask

   task automatic wait_ticks(input int n);
      int t0;
      t0 = tick_cnt;
      wait (tick_cnt >= t0 + n);
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit rec);
      if (rec) btn_recall = 1'b1;
      else     btn_lap = 1'b1;
      wait_ticks(DEB + 2);
      btn_recall = 1'b0;
      btn_lap = 1'b0;
      wait_ticks(DEB + 2);
   endtask

   // returns 1 when the model captured a lap
   function automatic bit model_lap();
      if (m_mode == 1) begin
         m_mode = 0;
         return 1'b0;
      end
      if (!running) return 1'b0;
      if (m_laps.size() >= 4) begin
         m_ovf = 1'b1;
         return 1'b0;
      end
      m_laps.push_back(time_bcd);
`ifdef LAP_HOLD_EN
      m_mode = 2;
      m_idx = m_laps.size() - 1;
`endif
      return 1'b1;
   endfunction

   task automatic after_capture(input string nm);
      expect_now(nm);
`ifdef LAP_HOLD_EN
      time_bcd = rand_bcd();
      wait_ticks(HT / 2);
      expect_now({nm, "_hold"});
      time_bcd = rand_bcd();
      wait_ticks(HT / 2 + 3);
      m_mode = 0;
      expect_now({nm, "_hold_end"});
`endif
   endtask

   task automatic do_lap(input string nm);
      bit cap;
      time_bcd = rand_bcd();
      press(1'b0);
      cap = model_lap();
      if (cap) after_capture(nm);
      else     expect_now(nm);
   endtask

   task automatic do_recall(input string nm);
      press(1'b1);
      if (m_mode == 1) begin
         m_idx = (m_idx + 1) % m_laps.size();
      end else if (m_laps.size() > 0) begin
         m_mode = 1;
         m_idx = 0;
      end
      expect_now(nm);
   endtask

   task automatic do_clear(input string nm);
      clear_laps = 1'b1;
      @(posedge clk);
      #1 clear_laps = 1'b0;
      m_laps.delete();
      m_ovf = 1'b0;
      m_mode = 0;
      m_idx = 0;
      time_bcd = rand_bcd();
      expect_now(nm);
      push_exp({nm, "_idx"}, time_bcd, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
   endtask

   task automatic do_idle(input string nm);
      wait_ticks(RT + 3);
      if (m_mode == 1) m_mode = 0;
      time_bcd = rand_bcd();
      expect_now(nm);
   endtask

   initial begin
      bit cap;
      // reset, lap button held through reset release
      running = 1'b1;
      time_bcd = 16'h1234;
      btn_lap = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      push_exp("reset", 16'h0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
      rst_n = 1'b1;
      wait_ticks(DEB + 4);
      expect_now("held_through_reset");
      btn_lap = 1'b0;
      wait_ticks(DEB + 2);
      expect_now("held_release");

      // first capture of a fixed value
      press(1'b0);
      cap = model_lap();
      after_capture("lap_1234");
      do_recall("recall_entry0");
      do_lap("lap_exits_recall");

      // bouncing lap press
      time_bcd = rand_bcd();
      for (int i = 0; i < 3; i++) begin
         btn_lap = ~btn_lap;
         repeat (TP / 2) @(posedge clk);
         #1;
      end
      btn_lap = 1'b1;
      wait_ticks(DEB + 2);
      btn_lap = 1'b0;
      wait_ticks(DEB + 2);
      cap = model_lap();
      after_capture("bounce_one_capture");

      // fill and overflow
      do_lap("lap_3");
      do_lap("lap_4");
      do_lap("lap_overflow");
      for (int i = 0; i < 5; i++) do_recall($sformatf("walk4_%0d", i));
      do_idle("recall_timeout_4");

      // clear held over a lap press
      clear_laps = 1'b1;
      time_bcd = rand_bcd();
      press(1'b0);
      clear_laps = 1'b0;
      m_laps.delete();
      m_ovf = 1'b0;
      m_mode = 0;
      m_idx = 0;
      push_exp("clear_beats_lap", time_bcd, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);

      do_recall("recall_empty_ignored");

      // three laps, recall four times, then timeout
      for (int i = 0; i < 3; i++) do_lap($sformatf("three_%0d", i));
      for (int i = 0; i < 4; i++) do_recall($sformatf("walk3_%0d", i));
      do_idle("recall_timeout_3");

      running = 1'b0;
      do_lap("lap_stopped_ignored");
      running = 1'b1;

      // randomized operation mix
      for (int n = 0; n < 40; n++) begin
         int op;
         op = $urandom_range(9);
         if (op <= 3)      do_lap($sformatf("rnd%0d_lap", n));
         else if (op <= 6) do_recall($sformatf("rnd%0d_rec", n));
         else if (op == 7) do_clear($sformatf("rnd%0d_clr", n));
         else if (op == 8) begin
            running = ~running;
            time_bcd = rand_bcd();
            expect_now($sformatf("rnd%0d_run", n));
         end else begin
            do_idle($sformatf("rnd%0d_idle", n));
         end
      end

      repeat (4) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, 0 required", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lap_display_ctrl.md
LAP_DISPLAY_CTRL -- requirements
Module: lap_display_ctrl

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 2, meaning consecutive tick_10ms samples a button level must be stable before it is accepted.
REQ-002 SHALL have parameter RECALL_TICKS, default 500, meaning tick_10ms periods with no press before RECALL returns to LIVE (5 s).
REQ-003 SHALL have parameter HOLD_TICKS, default 100, meaning tick_10ms periods a captured split is frozen on display (LAP_HOLD_EN only).
REQ-004 SHALL have port clk, input, 1 bit, 100 MHz board clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port tick_10ms, input, 1 bit, one-clk pulse every 10 ms from the clock divider.
REQ-007 SHALL have port btn_lap, input, 1 bit, raw asynchronous lap button.
REQ-008 SHALL have port btn_recall, input, 1 bit, raw asynchronous recall button.
REQ-009 SHALL have port running, input, 1 bit, high while the stopwatch counts (up or down).
REQ-010 SHALL have port clear_laps, input, 1 bit, one-clk pulse from the stopwatch reset/load press.
REQ-011 SHALL have port time_bcd, input, 16 bits, live time {sec_tens, sec_ones, msec_tens, msec_ones}.
REQ-012 SHALL have port disp_bcd, output, 16 bits, registered value to the 7-segment multiplexer.
REQ-013 SHALL have port disp_is_lap, output, 1 bit, high when disp_bcd shows a stored lap.
REQ-014 SHALL have port lap_idx, output, 2 bits, index of the lap shown (0 = oldest).
REQ-015 SHALL have port lap_count, output, 3 bits, number of stored laps, 0..4.
REQ-016 SHALL have port overflow, output, 1 bit, sticky flag: a lap was dropped because the buffer was full.

Function
REQ-017 SHALL synchronise each button through two flops, then debounce: the accepted level changes only after the synced level differs from it on DEB_TICKS consecutive tick_10ms samples; any mismatch-free sample resets the count.
REQ-018 SHALL generate a one-clk press event on each 0->1 change of an accepted level; releases generate nothing.
REQ-019 SHALL store laps in a 4-entry x 16-bit buffer written in order; entry k holds the k-th capture since the last clear.
REQ-020 SHALL implement states LIVE, RECALL and (LAP_HOLD_EN only) HOLD; reset state LIVE.
REQ-021 LIVE: disp_bcd SHALL equal time_bcd delayed by one clk; disp_is_lap = 0.
REQ-022 LIVE, lap press, running = 1, lap_count < 4: SHALL write time_bcd of that clk to entry lap_count and increment lap_count.
REQ-023 Lap press with lap_count = 4: SHALL drop the capture, set overflow, leave buffer unchanged.
REQ-024 Lap press with running = 0 in LIVE SHALL be ignored.
REQ-025 LIVE, recall press, lap_count > 0: SHALL go to RECALL with lap_idx = 0; with lap_count = 0 SHALL be ignored.
REQ-026 RECALL: disp_bcd SHALL equal entry lap_idx (one-clk latency), disp_is_lap = 1.
REQ-027 RECALL, recall press: lap_idx SHALL increment, wrapping to 0 after lap_count-1.
REQ-028 RECALL, lap press: SHALL return to LIVE without capturing.
REQ-029 RECALL SHALL return to LIVE after RECALL_TICKS tick_10ms pulses with no press; each press restarts the count.
REQ-030 clear_laps SHALL, next clk, set lap_count = 0, lap_idx = 0, overflow = 0, state LIVE; it wins over any same-cycle press.
REQ-031 Lap and recall presses in the same clk: lap SHALL take priority, recall discarded.

Reset
REQ-032 rst_n low SHALL immediately force: state LIVE, disp_bcd = 0, disp_is_lap = 0, lap_idx = 0, lap_count = 0, overflow = 0, debounce levels and counters 0, timers 0.
REQ-033 Buffer contents need not reset; unwritten entries are never displayed.
REQ-034 Reset deassertion mid-press SHALL not produce a press event until the button is released and pressed again.

Configuration
REQ-035 Macro LAP_HOLD_EN defined: each successful capture (REQ-022) SHALL enter HOLD, showing the captured value with disp_is_lap = 1 and lap_idx = capture index for HOLD_TICKS ticks, then LIVE; lap press in HOLD captures again and restarts hold; recall press behaves as in LIVE.
REQ-036 LAP_HOLD_EN undefined: no HOLD state; capture leaves the display in LIVE.

Verification
REQ-037 Reset, running = 1, time_bcd = 16'h1234, press lap 30 ms -> lap_count = 1, entry 0 = 16'h1234, disp_is_lap = 0.
REQ-038 Lap bounces toggling every 5 ms for 15 ms, then stable 30 ms -> exactly one capture.
REQ-039 Five captures while running -> lap_count = 4, overflow = 1, entries hold captures 1-4.
REQ-040 Three laps stored, recall pressed 4 times -> lap_idx 0,1,2,0, disp_bcd tracks entries; idle 5 s -> LIVE.
REQ-041 clear_laps same clk as lap press event -> lap_count = 0, overflow = 0, no capture.
REQ-042 LAP_HOLD_EN, capture 16'h0550 -> disp_bcd = 16'h0550 for 100 ticks while time_bcd advances, then live.
